// File: rtl/rr_grant_pkg.sv
// Shared types for the rr_grant_ctrl request/grant sequencer.
// State encoding is fixed because STATE is exported as a raw 2-bit field.
package rr_grant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between a requester block (master) and rr_grant_ctrl (slave).
interface rr_grant_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] REQ;
    logic              MODE;
    logic              DONE_IN;
    logic              HOLD;
    logic [NUM_CH-1:0] GNT;
    logic [ID_W-1:0]   CH_ID;
    logic              BUSY;
    logic              TIMEOUT;
    logic [1:0]        STATE;

    modport master (output REQ, MODE, DONE_IN, HOLD,
                    input  GNT, CH_ID, BUSY, TIMEOUT, STATE);
    modport slave  (input  REQ, MODE, DONE_IN, HOLD,
                    output GNT, CH_ID, BUSY, TIMEOUT, STATE);
endinterface

// File: rtl/rr_pick.sv
// Combinational winner select: lowest set index, or first set index at/after ptr with wrap.
// Wrap-around is handled by searching a doubled request vector masked below ptr.
module rr_pick
    import rr_grant_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    input  logic              mode,
    output logic [ID_W-1:0]   win,
    output logic              vld
);

    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] mask;
    logic [ID_W-1:0]     base;

    always_comb begin
        base = (mode == MODE_RR) ? ptr : '0;
        dbl  = {req, req};
        for (int i = 0; i < 2*NUM_CH; i++) begin
            mask[i] = (i >= int'(base));
        end
        // Scan downward so the lowest qualifying bit is the last one assigned.
        win = '0;
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (dbl[i] && mask[i]) win = ID_W'(i % NUM_CH);
        end
        vld = |req;
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Request/grant sequencer: fixed-priority or round-robin arbitration, watchdog
// timeout on long grants, and a fixed recovery interval after each timeout.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ID_W        = $clog2(NUM_CH),
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 200,
    parameter int RECOVER_CYC = 3
) (
    input  logic          CK,
    input  logic          RST,
    rr_grant_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]   chid_q, chid_d;
    logic              tmo_q, tmo_d;

    logic [ID_W-1:0]   pick_win;
    logic              pick_vld;

    rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
        .req  (bus.REQ),
        .ptr  (ptr_q),
        .mode (bus.MODE),
        .win  (pick_win),
        .vld  (pick_vld)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            chid_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            chid_q  <= chid_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        chid_d  = chid_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_BUSY;
                    gnt_d   = NUM_CH'(1) << pick_win;
                    chid_d  = pick_win;
                    cnt_d   = '0;
                    ptr_d   = (pick_win == ID_W'(NUM_CH-1)) ? '0 : pick_win + 1'b1;
                end
            end
            ST_BUSY: begin
                // DONE_IN beats both HOLD and the watchdog.
                if (bus.DONE_IN) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                end else if (!bus.HOLD) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
                        state_d = ST_RECOVER;
                        gnt_d   = '0;
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            ST_RECOVER: begin
                if (cnt_q == CNT_W'(RECOVER_CYC-1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.GNT     = gnt_q;
    assign bus.CH_ID   = chid_q;
    assign bus.BUSY    = (state_q == ST_BUSY);
    assign bus.TIMEOUT = tmo_q;
    assign bus.STATE   = state_q;

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Parametrised successor of our small 5-flop benchmark controllers: a synchronous request/grant sequencer with NUM_CH request channels, a selectable arbitration mode, a watchdog timeout and a recovery interval.
- Intended as a scalable sequential benchmark core for locking/obfuscation experiments: width, channel count and timing are set by parameters, not hard-coded.

Parameters:
- NUM_CH, 4, number of request/grant channels (>=2)
- ID_W, $clog2(NUM_CH), width of the channel index
- CNT_W, 8, cycle counter width
- TIMEOUT_CYC, 200, maximum grant length in cycles; 1 <= TIMEOUT_CYC <= 2^CNT_W-1
- RECOVER_CYC, 3, length of the recovery interval after a timeout; 1 <= RECOVER_CYC <= 2^CNT_W-1

Ports:
- CK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; synchronous, active-high
- REQ  in  NUM_CH  per-channel request level
- MODE  in  1  0 = fixed priority (lowest index wins), 1 = round-robin; sampled only in IDLE
- DONE_IN  in  1  granted channel finished; sampled only in BUSY
- HOLD  in  1  freezes the grant counter while in BUSY
- GNT  out  NUM_CH  registered one-hot grant, all-zero when idle
- CH_ID  out  ID_W  index of the current or last granted channel
- BUSY  out  1  high exactly while the state is BUSY
- TIMEOUT  out  1  one-cycle registered pulse on watchdog expiry
- STATE  out  2  encoded state: IDLE=00, BUSY=01, RELEASE=10, RECOVER=11

Behaviour:
- Reset values: STATE=IDLE, GNT=0, CH_ID=0, BUSY=0, TIMEOUT=0, counter=0, round-robin pointer ptr=0.
- RST overrides every other input, including mid-grant: the cycle after RST is sampled high, all reset values hold and no TIMEOUT pulse is produced.
- IDLE
  - If REQ!=0, pick a winner w.
  - MODE=0: w is the lowest set index.
  - MODE=1: w is the first set index searching from ptr upward, wrapping from NUM_CH-1 to 0.
  - At the next edge: STATE=BUSY, GNT=onehot(w), CH_ID=w, counter=0, ptr=(w+1) mod NUM_CH.
  - ptr is updated in both modes.
  - Grant latency is 1 cycle from REQ sampled to GNT visible.
  - If REQ=0, stay in IDLE with all outputs unchanged.
- BUSY
  - DONE_IN=1 has priority over HOLD and over timeout: next STATE=RELEASE, GNT=0, no TIMEOUT pulse.
  - Else if HOLD=1: counter holds its value.
  - Else if counter==TIMEOUT_CYC-1: next STATE=RECOVER, GNT=0, TIMEOUT=1 for one cycle, counter=0.
  - Else: counter increments by 1.
  - With no HOLD and no DONE_IN, GNT stays high for exactly TIMEOUT_CYC cycles.
  - REQ changes during BUSY (including the granted channel dropping its request) are ignored.
- RELEASE: lasts exactly one cycle with GNT=0, then IDLE. This guarantees at least one all-zero GNT cycle between grants.
- RECOVER
  - GNT=0; counter increments each cycle; HOLD and DONE_IN are ignored.
  - When counter==RECOVER_CYC-1, next STATE=IDLE and counter=0.
  - RECOVER therefore lasts RECOVER_CYC cycles.
- CH_ID keeps the last winner outside BUSY.
- Invariants: GNT is never multi-hot; GNT!=0 if and only if STATE=BUSY.
- Counter arithmetic is unsigned CNT_W-bit. Its maximum value is bounded by the parameter limits, so it never wraps.

Decomposition:
- Shared package rr_grant_pkg holds:
  - the state enum with fixed 2-bit encoding (IDLE/BUSY/RELEASE/RECOVER);
  - localparams for the MODE encodings.
- One sub-module, rr_pick: purely combinational. Inputs are REQ, ptr and MODE; outputs are winner index and a valid flag. It uses a double-width masked priority search for the wrap-around.
- Top level holds the FSM, counter, ptr and output registers.

Test Plan:
1. NUM_CH=4, MODE=1, REQ=4'b1111, DONE_IN pulsed 2 cycles after each grant -> GNT sequence 0001,0010,0100,1000,0001, each separated by exactly one GNT=0 RELEASE cycle.
2. MODE=0, REQ=4'b1100 held, repeated DONE -> every grant is 0100; CH_ID=2.
3. TIMEOUT_CYC=8, RECOVER_CYC=3, REQ=4'b0001, no DONE -> GNT high 8 cycles; TIMEOUT=1 for 1 cycle when STATE becomes 11; STATE=11 for 3 cycles, then 00; regrant on the next edge.
4. HOLD=1 for 5 cycles mid-grant with TIMEOUT_CYC=8 -> GNT high 13 cycles before TIMEOUT; DONE_IN and HOLD together in a cycle -> RELEASE, no TIMEOUT.
5. DONE_IN asserted in the cycle where counter==TIMEOUT_CYC-1 -> STATE=10, TIMEOUT stays 0.
6. RST=1 asserted during BUSY (counter=5) -> next cycle all outputs 0, STATE=00, ptr=0; with MODE=1 and REQ=4'b1010, the first grant after reset is 0010.
